// File: rtl/aes_spi_pkg.sv
// Shared types and widths for the AES block SPI master and its slave side.
package aes_spi_pkg;
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam int AES_BLOCK_W = 128;
  localparam int DIV_CNT_W   = 8;
  localparam int BIT_CNT_W   = $clog2(AES_BLOCK_W + 1);
endpackage

// File: rtl/aes_spi_master_if.sv
// Host handshake and SPI pins of the AES block SPI master.
interface aes_spi_master_if #(
  parameter int DATA_W = 128
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, cs_n, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_sclk_div.sv
// SCLK half-period timer; tick every CLK_DIV enabled cycles, rise/fall
// split the ticks by the current SCLK phase.
module spi_sclk_div
  import aes_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic phase
);
  localparam logic [DIV_CNT_W-1:0] LAST =
    DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);
  assign rise = tick && !phase;
  assign fall = tick && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else if (en) begin
      cnt   <= cnt + DIV_CNT_W'(1);
    end
  end
endmodule

// File: rtl/aes_spi_master.sv
// SPI mode-0 master moving one AES block per frame.
// Define AES_SPI_MASTER_LSB_FIRST_EN for LSB-first frames.
module aes_spi_master
  import aes_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = AES_BLOCK_W
) (
  input logic              clk,
  input logic              rst_n,
  aes_spi_master_if.master bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(DATA_W);

  state_t state, state_nx;

  logic [DATA_W-1:0] tx_sr, rx_sr, rx_q;
  logic [DATA_W-1:0] tx_nx, rx_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic tx_bit, accept, active;
  logic div_en, div_clr, tick, rise, fall, phase;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall),
    .phase (phase)
  );

  assign accept = (state == IDLE) && bus.start;
  assign active = state inside {SETUP, SHIFT, HOLD};
  assign div_en = active;
  // Restart the divider at SHIFT entry so SCLK begins low for a full half-period
  assign div_clr = !active || ((state == SETUP) && tick);

`ifdef AES_SPI_MASTER_LSB_FIRST_EN
  assign tx_bit = tx_sr[0];
  assign tx_nx  = {1'b0, tx_sr[DATA_W-1:1]};
  assign rx_nx  = {bus.miso, rx_sr[DATA_W-1:1]};
`else
  assign tx_bit = tx_sr[DATA_W-1];
  assign tx_nx  = {tx_sr[DATA_W-2:0], 1'b0};
  assign rx_nx  = {rx_sr[DATA_W-2:0], bus.miso};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.start) state_nx = SETUP;
      SETUP: if (tick) state_nx = SHIFT;
      SHIFT: if (fall && (bit_cnt == BIT_END)) state_nx = HOLD;
      HOLD:  if (tick) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      rx_q    <= '0;
    end else begin
      if (accept) begin
        tx_sr   <= bus.tx_data;
        rx_sr   <= '0;
        bit_cnt <= '0;
      end
      if ((state == SHIFT) && rise) begin
        rx_sr   <= rx_nx;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if ((state == SHIFT) && fall) tx_sr <= tx_nx;
      if ((state == HOLD) && tick) rx_q <= rx_sr;
    end
  end

  assign bus.sclk    = (state == SHIFT) && phase;
  assign bus.cs_n    = !active;
  assign bus.busy    = active;
  assign bus.done    = (state == DONE);
  assign bus.mosi    = active && tx_bit;
  assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_aes_spi_master.sv
// Scoreboard bench for aes_spi_master: driver queues expected frames,
// a negedge monitor checks every completed frame and the idle lines.
module tb_aes_spi_master;
  import aes_spi_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int W = 128;
  localparam int LAT = 258 * CLK_DIV + 1;
`ifdef AES_SPI_MASTER_LSB_FIRST_EN
  localparam int FIRST_ONE = 0;
`else
  localparam int FIRST_ONE = W - 1;
`endif

  typedef struct packed {
    logic [W-1:0] rx;
    logic [W-1:0] mo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop = 1'b1;
  logic miso_fix = 1'b0;

  aes_spi_master_if #(.DATA_W(W)) bus();
  assign bus.miso = loop ? bus.mosi : miso_fix;

  aes_spi_master #(.CLK_DIV(CLK_DIV), .DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  exp_t e;
  int acc_cyc = 0;
  int rise_cnt = 0;
  int first_one = -1;
  int last_first_one = -1;
  int done_cnt = 0;
  logic [W-1:0] cap = '0;
  logic [W-1:0] last_rx = '0;
  logic sclk_q = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] mo_exp(input logic [W-1:0] tx);
    logic [W-1:0] r;
`ifdef AES_SPI_MASTER_LSB_FIRST_EN
    for (int i = 0; i < W; i++) r[i] = tx[W-1-i];
`else
    r = tx;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      rise_cnt = 0;
      sclk_q = 1'b0;
      last_rx = '0;
    end else begin
      if (bus.start && !bus.busy && !bus.done) begin
        acc_cyc = cyc;
        rise_cnt = 0;
        cap = '0;
        first_one = -1;
      end
      if (bus.sclk && !sclk_q) begin
        if (bus.mosi && first_one < 0) first_one = rise_cnt;
        cap = {cap[W-2:0], bus.mosi};
        rise_cnt++;
      end
      sclk_q = bus.sclk;
      if (bus.cs_n) chk("idle_lines", W'({bus.sclk, bus.mosi}), '0);
      if (bus.done) begin
        done_cnt++;
        last_first_one = first_one;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty queue");
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", bus.rx_data, e.rx);
          chk("mosi_bits", cap, e.mo);
          chk("latency", W'(cyc - acc_cyc), W'(LAT));
          chk("sclk_rises", W'(rise_cnt), W'(W));
          chk("done_busy", W'(bus.busy), '0);
          last_rx = e.rx;
        end
      end else begin
        chk("rx_hold", bus.rx_data, last_rx);
      end
    end
  end

  task automatic send(input logic [W-1:0] tx, input logic [W-1:0] rx);
    exp_t x;
    x.rx = rx;
    x.mo = mo_exp(tx);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.tx_data = tx;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.tx_data = {4{$urandom()}};
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL %s: got no done expected done within 3000 cycles", name);
    end
  endtask

  task automatic wait_rises(input int k);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rise_cnt >= k) break;
    end
    checks++;
    if (rise_cnt < k) begin
      errors++;
      $display("FAIL rise_wait: got %0d rises expected %0d", rise_cnt, k);
    end
  endtask

  localparam logic [W-1:0] AES_V = 128'h00112233445566778899aabbccddeeff;
  localparam logic [W-1:0] PAT3 = 128'h0123456789abcdef0fedcba987654321;
  localparam logic [W-1:0] PAT4 = 128'ha5a5c3c3_0f0f_1234_8001_deadbeef5a5a;

  int d0;

  initial begin
    bus.start = 1'b0;
    bus.tx_data = '0;
    #2;
    chk("rst_cs_n", W'(bus.cs_n), W'(1));
    chk("rst_sclk", W'(bus.sclk), '0);
    chk("rst_mosi", W'(bus.mosi), '0);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_rx", bus.rx_data, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(AES_V, AES_V);
    wait_done("s1");

    loop = 1'b0;
    miso_fix = 1'b1;
    send('0, '1);
    wait_done("s2");
    #1;
    loop = 1'b1;
    miso_fix = 1'b0;

    d0 = done_cnt;
    send(PAT3, PAT3);
    wait_rises(40);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.tx_data = '1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("s3");
    repeat (20) @(negedge clk);
    chk("one_done", W'(done_cnt - d0), W'(1));

    send(PAT4, PAT4);
    wait_rises(60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cs_n", W'(bus.cs_n), W'(1));
    chk("arst_sclk", W'(bus.sclk), '0);
    chk("arst_busy", W'(bus.busy), '0);
    chk("arst_rx", bus.rx_data, '0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    send(PAT4, PAT4);
    wait_done("s4");

    send(AES_V, AES_V);
    wait_done("s5a");
    send(~AES_V, ~AES_V);
    wait_done("s5b");

    send(128'h1, 128'h1);
    wait_done("s6");
    #1;
    chk("first_one", W'(last_first_one), W'(FIRST_ONE));

    repeat (5) @(negedge clk);
    chk("queue_empty", W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
